// File: rtl/game_pkg.sv
// rtl/game_pkg.sv - colour codes, FSM states and helpers shared by the memory game
package game_pkg;

  localparam logic [1:0] COL_YELLOW = 2'b00;
  localparam logic [1:0] COL_RED    = 2'b01;
  localparam logic [1:0] COL_BLUE   = 2'b10;
  localparam logic [1:0] COL_GREEN  = 2'b11;

  localparam int DEPTH_DEFAULT = 64;

  typedef enum logic {
    WAIT_REL = 1'b0,
    ARMED    = 1'b1
  } fsm_state_t;

  // Button pattern bit order is {green, blue, red, yellow}, so the bit index equals the colour code.
  function automatic logic [1:0] encode_btn(input logic [3:0] pat);
    logic [1:0] code;
    code = COL_YELLOW;
    case (pat)
      4'b0001: code = COL_YELLOW;
      4'b0010: code = COL_RED;
      4'b0100: code = COL_BLUE;
      4'b1000: code = COL_GREEN;
      default: code = COL_YELLOW;
    endcase
    return code;
  endfunction

  function automatic logic is_multi(input logic [3:0] pat);
    return (pat & (pat - 4'd1)) != 4'd0;
  endfunction

endpackage

// File: rtl/button_debounce.sv
// rtl/button_debounce.sv - stability counter and pattern compare for the colour buttons
module button_debounce
  import game_pkg::*;
#(
  parameter int DEBOUNCE = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_run,
  input  logic       i_armed,
  input  logic [3:0] i_pattern,
  output logic [3:0] o_stable_pattern,
  output logic       o_accept,
  output logic       o_released,
  output logic       o_multi_start
);

  localparam int CNT_W = $clog2(DEBOUNCE + 1);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(DEBOUNCE);

  logic [CNT_W-1:0] r_cnt;
  logic [3:0]       r_prev;
  logic [CNT_W-1:0] w_cnt_next;
  logic [CNT_W-1:0] w_cnt_inc;
  logic [CNT_W-1:0] w_run_len;
  logic             w_multi;

  assign w_cnt_inc        = r_cnt + 1'b1;
  assign w_multi          = is_multi(i_pattern);
  assign o_stable_pattern = i_pattern;

  always_comb begin
    w_cnt_next    = r_cnt;
    w_run_len     = '0;
    o_accept      = 1'b0;
    o_released    = 1'b0;
    o_multi_start = 1'b0;
    if (!i_run) begin
      w_cnt_next = '0;
    end else if (!i_armed) begin
      if (i_pattern == 4'd0) begin
        if (w_cnt_inc >= LIMIT) begin
          o_released = 1'b1;
          w_cnt_next = '0;
        end else begin
          w_cnt_next = w_cnt_inc;
        end
      end else begin
        w_cnt_next = '0;
      end
    end else if (w_multi) begin
      w_cnt_next    = '0;
      o_multi_start = !is_multi(r_prev);
    end else if (i_pattern == 4'd0) begin
      w_cnt_next = '0;
    end else begin
      // A changed single-button pattern starts a fresh run of length one.
      w_run_len = (i_pattern == r_prev) ? w_cnt_inc : CNT_W'(1);
      if (w_run_len >= LIMIT) begin
        o_accept   = 1'b1;
        w_cnt_next = '0;
      end else begin
        w_cnt_next = w_run_len;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt  <= '0;
      r_prev <= 4'd0;
    end else begin
      r_cnt  <= w_cnt_next;
      r_prev <= i_pattern;
    end
  end

endmodule

// File: rtl/color_input_encoder.sv
// rtl/color_input_encoder.sv - debounced colour buttons written into X/Y bit-planes
module color_input_encoder
  import game_pkg::*;
#(
  parameter int DEPTH    = DEPTH_DEFAULT,
  parameter int IDX_W    = 8,
  parameter int DEBOUNCE = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             clear,
  input  logic             btn_yellow,
  input  logic             btn_red,
  input  logic             btn_blue,
  input  logic             btn_green,
  output logic [DEPTH-1:0] X,
  output logic [DEPTH-1:0] Y,
  output logic [IDX_W-1:0] count,
  output logic             entry_valid,
  output logic [1:0]       entry_color,
  output logic             full,
  output logic             multi_err
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [IDX_W-1:0] DEPTH_C = IDX_W'(DEPTH);

  fsm_state_t       r_state;
  fsm_state_t       w_state_next;
  logic [DEPTH-1:0] r_x;
  logic [DEPTH-1:0] r_y;
  logic [IDX_W-1:0] r_count;
  logic             r_entry_valid;
  logic [1:0]       r_entry_color;
  logic             r_full;
  logic             r_multi_err;

  logic [3:0]       w_pattern;
  logic [3:0]       w_stable;
  logic             w_run;
  logic             w_accept;
  logic             w_released;
  logic             w_multi_start;
  logic             w_commit;
  logic [1:0]       w_code;
  logic [IDX_W-1:0] w_count_inc;
  logic [AW-1:0]    w_idx;

  assign w_pattern = {btn_green, btn_blue, btn_red, btn_yellow};
  assign w_run     = en && !clear;

  button_debounce #(
    .DEBOUNCE(DEBOUNCE)
  ) u_debounce (
    .clk              (clk),
    .rst_n            (rst_n),
    .i_run            (w_run),
    .i_armed          (r_state == ARMED),
    .i_pattern        (w_pattern),
    .o_stable_pattern (w_stable),
    .o_accept         (w_accept),
    .o_released       (w_released),
    .o_multi_start    (w_multi_start)
  );

  always_comb begin
    w_state_next = r_state;
    if (!w_run) begin
      w_state_next = WAIT_REL;
    end else begin
      case (r_state)
        WAIT_REL: if (w_released) w_state_next = ARMED;
        ARMED:    if (w_accept)   w_state_next = WAIT_REL;
        default:  w_state_next = WAIT_REL;
      endcase
    end
  end

  // An accepted press while full still returns to WAIT_REL but writes nothing.
  assign w_commit    = w_accept && !r_full;
  assign w_code      = encode_btn(w_stable);
  assign w_count_inc = r_count + 1'b1;
  assign w_idx       = r_count[AW-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= WAIT_REL;
      r_x           <= '0;
      r_y           <= '0;
      r_count       <= '0;
      r_entry_valid <= 1'b0;
      r_entry_color <= COL_YELLOW;
      r_full        <= 1'b0;
      r_multi_err   <= 1'b0;
    end else begin
      r_state <= w_state_next;
      if (clear) begin
        r_x           <= '0;
        r_y           <= '0;
        r_count       <= '0;
        r_entry_valid <= 1'b0;
        r_entry_color <= COL_YELLOW;
        r_full        <= 1'b0;
        r_multi_err   <= 1'b0;
      end else begin
        r_entry_valid <= w_commit;
        r_multi_err   <= w_multi_start;
        if (w_commit) begin
          r_x[w_idx]    <= w_code[1];
          r_y[w_idx]    <= w_code[0];
          r_count       <= w_count_inc;
          r_entry_color <= w_code;
          r_full        <= (w_count_inc == DEPTH_C);
        end
      end
    end
  end

  assign X           = r_x;
  assign Y           = r_y;
  assign count       = r_count;
  assign entry_valid = r_entry_valid;
  assign entry_color = r_entry_color;
  assign full        = r_full;
  assign multi_err   = r_multi_err;

endmodule
